// File: rtl/apb_slave_regfile17.sv
// APB3 slave register file: ID register at index 0, read/write registers above it,
// fixed number of wait states and error responses for out-of-range or ID writes.
module apb_slave_regfile17 #(
  parameter int                      PADDR_WIDTH  = 32,
  parameter int                      PWDATA_WIDTH = 32,
  parameter int                      PRDATA_WIDTH = 32,
  parameter int                      NUM_REGS     = 16,
  parameter logic [PADDR_WIDTH-1:0]  BASE_ADDR    = '0,
  parameter int                      WAIT_STATES  = 1,
  parameter logic [PRDATA_WIDTH-1:0] ID_VALUE     = 32'hA9B0_0017
) (
  input  logic                    pclock17,
  input  logic                    preset17,
  input  logic                    psel17,
  input  logic                    penable17,
  input  logic [PADDR_WIDTH-1:0]  paddr17,
  input  logic                    prwd17,
  input  logic [PWDATA_WIDTH-1:0] pwdata17,
  output logic [PRDATA_WIDTH-1:0] prdata17,
  output logic                    pready17,
  output logic                    pslverr17
);

  localparam int IDX_W = $clog2(NUM_REGS);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t                   state_reg, state_next;
  logic [3:0]               cnt_reg, cnt_next;
  logic [IDX_W-1:0]         idx_reg;
  logic                     wr_reg, err_reg;
  logic [PWDATA_WIDTH-1:0]  wdata_reg;
  logic [PRDATA_WIDTH-1:0]  regs [NUM_REGS];
  logic [NUM_REGS-1:0]      wr_en;
  logic [PRDATA_WIDTH-1:0]  prdata_reg;
  logic                     pready_reg, pslverr_reg;

  logic [PADDR_WIDTH-1:0]   off, word;
  logic                     setup, setup_err, commit;
  logic [IDX_W-1:0]         cur_idx;
  logic                     cur_wr, cur_err;
  logic [PRDATA_WIDTH-1:0]  rd_data;

  // Address decode; the subtraction wraps, so addresses below the base are caught separately.
  assign off       = paddr17 - BASE_ADDR;
  assign word      = off >> 2;
  assign setup_err = (paddr17 < BASE_ADDR) || (word >= PADDR_WIDTH'(NUM_REGS)) ||
                     (prwd17 && (word == '0));
  assign setup     = (state_reg == IDLE) && psel17 && !penable17;

  // A zero-wait transfer enters DONE on the setup edge, so the live decode is used then.
  assign cur_idx = setup ? word[IDX_W-1:0] : idx_reg;
  assign cur_wr  = setup ? prwd17          : wr_reg;
  assign cur_err = setup ? setup_err       : err_reg;
  assign rd_data = (cur_idx == '0) ? ID_VALUE : regs[cur_idx];

  assign commit = (state_reg == DONE) && wr_reg && !err_reg;

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_wr_en
      assign wr_en[gi] = commit && (idx_reg == IDX_W'(gi));
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (setup) begin
          if (WAIT_STATES == 0) begin
            state_next = DONE;
            cnt_next   = '0;
          end else begin
            state_next = ACCESS;
            cnt_next   = 4'(WAIT_STATES);
          end
        end
      end
      ACCESS: begin
        if (!psel17) begin
          state_next = IDLE;
        end else if (penable17) begin
          cnt_next = cnt_reg - 4'd1;
          if (cnt_reg == 4'd1) state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge pclock17 or negedge preset17) begin
    if (!preset17) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      wr_reg    <= 1'b0;
      err_reg   <= 1'b0;
      wdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (setup) begin
        idx_reg   <= word[IDX_W-1:0];
        wr_reg    <= prwd17;
        err_reg   <= setup_err;
        wdata_reg <= pwdata17;
      end
    end
  end

  // Register 0 is never written (ID writes are errors); it reads back as ID_VALUE.
  always_ff @(posedge pclock17 or negedge preset17) begin
    if (!preset17) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_en[i]) regs[i] <= wdata_reg;
      end
    end
  end

  always_ff @(posedge pclock17 or negedge preset17) begin
    if (!preset17) begin
      prdata_reg  <= '0;
      pready_reg  <= 1'b0;
      pslverr_reg <= 1'b0;
    end else begin
      pready_reg  <= (state_next == DONE);
      pslverr_reg <= (state_next == DONE) && cur_err;
      prdata_reg  <= ((state_next == DONE) && !cur_wr && !cur_err) ? rd_data : '0;
    end
  end

  assign prdata17  = prdata_reg;
  assign pready17  = pready_reg;
  assign pslverr17 = pslverr_reg;

endmodule

// File: doc/apb_slave_regfile17.md
# apb_slave_regfile17

APB3 slave register file that sits directly downstream of the APB slave interface. It consumes the master-driven bus signals (paddr17, prwd17, pwdata17, psel17, penable17) and produces the slave response (prdata17, pready17, pslverr17). It provides NUM_REGS word registers, a programmable number of wait states, and error responses for illegal accesses. It is the DUT-side responder that the APB UVC slave checks run against.

## Interface
- PADDR_WIDTH, 32: address width.
- PWDATA_WIDTH, 32: write data width.
- PRDATA_WIDTH, 32: read data width; must equal PWDATA_WIDTH.
- NUM_REGS, 16: number of word registers, 2..256.
- BASE_ADDR, 32'h0: byte address of register 0; word aligned.
- WAIT_STATES, 1: access-phase cycles with pready17 low before completion, 0..15.
- ID_VALUE, 32'hA9B0_0017: read-only contents of register 0.

Ports:
- pclock17 input 1: APB clock; all state updates on the rising edge.
- preset17 input 1: reset, asynchronous assert, active-low; deassertion is synchronous to pclock17 upstream.
- psel17 input 1: slave select.
- penable17 input 1: access phase strobe.
- paddr17 input PADDR_WIDTH: byte address.
- prwd17 input 1: direction; 1 = write, 0 = read.
- pwdata17 input PWDATA_WIDTH: write data.
- prdata17 output PRDATA_WIDTH: read data; registered.
- pready17 output 1: transfer completion; registered.
- pslverr17 output 1: error response; registered.

## Operation
- Decode: off = paddr17 − BASE_ADDR, with modulo 2^PADDR_WIDTH arithmetic. idx = off[PADDR_WIDTH-1:2]. paddr17[1:0] is ignored.
- An access is illegal in either case:
  - idx ≥ NUM_REGS, or paddr17 < BASE_ADDR (out of range);
  - a write to idx 0 (ID register).
- Register 0 always reads ID_VALUE. Registers 1..NUM_REGS-1 are read/write, with reset value 0.
- FSM states: IDLE, ACCESS, DONE.
  - IDLE: psel17=1 and penable17=0 (setup phase) → capture address, direction, wdata and error flag. Load wait counter with WAIT_STATES. Go to ACCESS, or to DONE directly if WAIT_STATES=0.
  - ACCESS: while psel17=1 and penable17=1, decrement counter. When counter reaches 1, go to DONE. psel17=0 → abort to IDLE.
  - DONE: pready17=1 for exactly one cycle. The transfer completes at the rising edge ending this cycle. Go to IDLE.
- A legal write updates the register at the completing edge only.
- An illegal write changes no state.
- Read data = register contents at the edge entering DONE.
- In DONE:
  - pslverr17 = error flag.
  - prdata17 = read data for a legal read.
  - prdata17 = 0 for writes and for illegal reads.
- Outside DONE: pready17=0, pslverr17=0, prdata17=0.
- penable17=1 while in IDLE without a preceding setup phase is ignored and produces no response.

## Timing
- Reset (preset17=0): all three outputs = 0, FSM = IDLE, registers 1.. = 0, counter = 0. This takes effect immediately, asynchronously.
- Reset during a transfer: the transfer is aborted and no write occurs.
- Setup phase in cycle T. Access phase starts in cycle T+1. pready17=1 in cycle T+1+WAIT_STATES. Transfer length = WAIT_STATES+2 cycles.
- WAIT_STATES=0: a zero-wait transfer, with pready17 high in the first access cycle.
- Back-to-back transfers: a setup phase in the cycle after DONE is accepted. Maximum throughput is one transfer per WAIT_STATES+2 cycles.
- Address, direction and wdata are sampled at the setup edge. Changes during the access phase are ignored.
- psel17 deasserted before DONE: return to IDLE on that edge, with no pready17 pulse and no write.

## Test plan
- Reset, then read 0x0 with WAIT_STATES=1 → pready17 high in the 3rd cycle of the transfer, prdata17=32'hA9B0_0017, pslverr17=0.
- Write 0xDEAD_BEEF to 0x8, then read 0x8 → read returns 0xDEAD_BEEF, pslverr17=0 both times, and the register changes only at the write completion edge.
- Write to 0x0, then read 0x40 with NUM_REGS=16 → pslverr17=1 with pready17 on both accesses, prdata17=0, ID unchanged.
- WAIT_STATES=0: back-to-back writes to 0x4 and 0xC with no idle cycle → each completes in 2 cycles, and both values read back.
- psel17 dropped mid-access on a write of 0x1234 to 0x4 (WAIT_STATES=3) → no pready17 pulse, 0x4 keeps its old value. The next transfer completes normally.
- preset17 asserted mid-write → outputs 0 immediately, target register reads 0 after reset, ID still reads ID_VALUE.
